// File: rtl/fabric2_mport_if.sv
// OCP-style point-to-point bus used on both sides of the fabric master port:
// command/address/data from the master, accept/response/read data back.
interface fabric2_mport_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m_addr;
  logic [2:0]              m_cmd;
  logic [DATA_WIDTH-1:0]   m_data;
  logic [DATA_WIDTH/8-1:0] m_byte_en;
  logic                    s_cmd_accept;
  logic [DATA_WIDTH-1:0]   s_data;
  logic [1:0]              s_resp;

  modport master (
    output m_addr, m_cmd, m_data, m_byte_en,
    input  s_cmd_accept, s_data, s_resp
  );

  modport slave (
    input  m_addr, m_cmd, m_data, m_byte_en,
    output s_cmd_accept, s_data, s_resp
  );
endinterface

// File: rtl/fabric2_mport.sv
// Fabric v2 master-port front end: decodes the destination port, tracks one
// transaction at a time, reports act/done/portno and answers misses/timeouts.
module fabric2_mport #(
  parameter int                    PORTNO_WIDTH = 11,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    TIMEOUT      = 0,
  parameter logic [ADDR_WIDTH-1:0] P0_BASE      = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] P0_MASK      = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] P1_BASE      = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] P1_MASK      = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] P2_BASE      = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0] P2_MASK      = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] P3_BASE      = 32'h3000_0000,
  parameter logic [ADDR_WIDTH-1:0] P3_MASK      = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] P4_BASE      = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] P4_MASK      = 32'hF000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  fabric2_mport_if.slave          cpu,
  fabric2_mport_if.master         sw,
  output logic                    act,
  output logic                    done,
  output logic [PORTNO_WIDTH-1:0] portno
);

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [1:0] RES_NULL = 2'b00;
  localparam logic [1:0] RES_ERR  = 2'b11;

  localparam logic [4:0][ADDR_WIDTH-1:0] BASE_A = {P4_BASE, P3_BASE, P2_BASE, P1_BASE, P0_BASE};
  localparam logic [4:0][ADDR_WIDTH-1:0] MASK_A = {P4_MASK, P3_MASK, P2_MASK, P1_MASK, P0_MASK};

  localparam int               CNT_W  = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Returns {hit, port}; scanning downwards lets the lowest-numbered region win.
  function automatic logic [PORTNO_WIDTH:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [PORTNO_WIDTH:0] res;
    res = '0;
    for (int i = 4; i >= 0; i--) begin
      if ((addr & MASK_A[i]) == BASE_A[i]) begin
        res = {1'b1, PORTNO_WIDTH'(i)};
      end
    end
    return res;
  endfunction

  state_t                  state_r;
  state_t                  next_s;
  logic [PORTNO_WIDTH-1:0] portno_r;
  logic                    rd_r;
  logic [CNT_W-1:0]        cnt_r;

  logic [PORTNO_WIDTH:0]   dec_s;
  logic                    is_rd_s;
  logic                    timeout_s;
  logic                    latch_s;
  logic                    act_s;
  logic                    done_s;
  logic                    acc_s;
  logic [2:0]              cmd_s;
  logic [1:0]              resp_s;
  logic [DATA_WIDTH-1:0]   sdata_s;
  logic [PORTNO_WIDTH-1:0] portno_s;

  assign dec_s     = decode(cpu.m_addr);
  assign is_rd_s   = (cpu.m_cmd == CMD_RD);
  assign timeout_s = (TIMEOUT != 0) && (cnt_r == TO_VAL);

  // Next-state and output decode; rst forces every output to its idle value.
  always_comb begin
    next_s   = state_r;
    latch_s  = 1'b0;
    act_s    = 1'b0;
    done_s   = 1'b0;
    acc_s    = 1'b0;
    cmd_s    = CMD_IDLE;
    resp_s   = RES_NULL;
    sdata_s  = '0;
    portno_s = portno_r;
    if (rst) begin
      next_s   = ST_IDLE;
      portno_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          portno_s = dec_s[PORTNO_WIDTH-1:0];
          if (cpu.m_cmd == CMD_IDLE) begin
            next_s = ST_IDLE;
          end else if (dec_s[PORTNO_WIDTH]) begin
            act_s   = 1'b1;
            latch_s = 1'b1;
            cmd_s   = cpu.m_cmd;
            acc_s   = sw.s_cmd_accept;
            if (!sw.s_cmd_accept) begin
              next_s = ST_CMD;
            end else if (is_rd_s) begin
              next_s = ST_RESP;
            end else begin
              done_s = 1'b1;
              next_s = ST_IDLE;
            end
          end else begin
            // Unmapped: swallow the command here; reads get an ERR next cycle.
            acc_s  = 1'b1;
            next_s = is_rd_s ? ST_ERR : ST_IDLE;
          end
        end
        ST_CMD: begin
          cmd_s = cpu.m_cmd;
          acc_s = sw.s_cmd_accept;
          if (sw.s_cmd_accept && !rd_r) begin
            done_s = 1'b1;
            next_s = ST_IDLE;
          end else if (timeout_s) begin
            // A read accept is not completion, so the abort still takes priority.
            cmd_s  = CMD_IDLE;
            acc_s  = 1'b1;
            done_s = 1'b1;
            next_s = ST_IDLE;
            if (rd_r) begin
              resp_s = RES_ERR;
            end else begin
              resp_s = RES_NULL;
            end
          end else if (sw.s_cmd_accept) begin
            next_s = ST_RESP;
          end else begin
            next_s = ST_CMD;
          end
        end
        ST_RESP: begin
          resp_s  = sw.s_resp;
          sdata_s = sw.s_data;
          if (sw.s_resp != RES_NULL) begin
            done_s = 1'b1;
            next_s = ST_IDLE;
          end else if (timeout_s) begin
            resp_s  = RES_ERR;
            sdata_s = '0;
            done_s  = 1'b1;
            next_s  = ST_IDLE;
          end else begin
            next_s = ST_RESP;
          end
        end
        ST_ERR: begin
          resp_s = RES_ERR;
          next_s = ST_IDLE;
        end
        default: begin
          next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched destination/command type, and cycles elapsed since act.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      portno_r <= '0;
      rd_r     <= 1'b0;
      cnt_r    <= '0;
    end else begin
      state_r <= next_s;
      if (latch_s) begin
        portno_r <= dec_s[PORTNO_WIDTH-1:0];
        rd_r     <= is_rd_s;
        cnt_r    <= CNT_W'(1);
      end else if (state_r == ST_CMD || state_r == ST_RESP) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign sw.m_addr        = cpu.m_addr;
  assign sw.m_data        = cpu.m_data;
  assign sw.m_byte_en     = cpu.m_byte_en;
  assign sw.m_cmd         = cmd_s;
  assign cpu.s_cmd_accept = acc_s;
  assign cpu.s_resp       = resp_s;
  assign cpu.s_data       = sdata_s;
  assign act              = act_s;
  assign done             = done_s;
  assign portno           = portno_s;

endmodule

// File: tb/tb_fabric2_mport.sv
// Randomized bench for fabric2_mport: each transaction's expected timeline is
// derived from accept delay, response delay and the timeout budget.
module tb_fabric2_mport;

  localparam int         T        = 8;
  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [1:0] RES_NULL = 2'd0;
  localparam logic [1:0] RES_DVA  = 2'd1;
  localparam logic [1:0] RES_ERR  = 2'd3;

  logic        clk;
  logic        rst;
  logic        act;
  logic        done;
  logic [10:0] portno;
  int          n_checks;
  int          n_errors;
  int          txn_id;

  fabric2_mport_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cpu_if ();
  fabric2_mport_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sw_if ();

  fabric2_mport #(.TIMEOUT(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .cpu    (cpu_if),
    .sw     (sw_if),
    .act    (act),
    .done   (done),
    .portno (portno)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " act"}, 32'(act), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " acc"}, 32'(cpu_if.s_cmd_accept), 32'd0);
    check({tag, " resp"}, 32'(cpu_if.s_resp), 32'(RES_NULL));
    check({tag, " sdata"}, cpu_if.s_data, 32'd0);
    check({tag, " mcmd"}, 32'(sw_if.m_cmd), 32'(CMD_IDLE));
    check({tag, " portno"}, 32'(portno), 32'd0);
  endtask

  // One transaction: a = cycle the slave accepts, r = cycles from accept to read response.
  task automatic run_txn(input logic rd, input logic [31:0] addr, input int a, input int r,
                         input logic [31:0] rdata, input int gap);
    int          port;
    logic        hit;
    logic        err;
    logic        cmd_to;
    int          c;
    int          end_k;
    int          last_k;
    int          cmd_k;
    logic [31:0] wdata;
    logic [2:0]  cmd;
    logic        e_act;
    logic        e_done;
    logic        e_acc;
    logic [2:0]  e_cmd;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    string       tg;

    txn_id++;
    port   = int'(addr >> 28);
    hit    = (port < 5);
    cmd    = rd ? CMD_RD : CMD_WR;
    wdata  = $urandom;
    c      = rd ? a + r : a;
    err    = hit && (c > T);
    cmd_to = hit && (rd ? (a >= T) : (a > T));
    if (hit) begin
      end_k  = err ? T : c;
      last_k = rd ? ((a + r > end_k) ? a + r : end_k) : end_k;
      cmd_k  = cmd_to ? T : a;
    end else begin
      end_k  = rd ? 1 : 0;
      last_k = end_k;
      cmd_k  = 0;
    end

    for (int k = 0; k <= last_k + gap; k++) begin
      #1;
      cpu_if.m_addr    = addr;
      cpu_if.m_data    = wdata;
      cpu_if.m_byte_en = 4'(k);
      cpu_if.m_cmd     = (k <= cmd_k) ? cmd : CMD_IDLE;
      sw_if.s_data     = rdata;
      if (!hit) sw_if.s_cmd_accept = 1'($urandom_range(0, 1));
      else if (k < a) sw_if.s_cmd_accept = 1'b0;
      else if (k == a) sw_if.s_cmd_accept = 1'b1;
      else sw_if.s_cmd_accept = 1'($urandom_range(0, 1));
      if (hit && rd && k == a + r) sw_if.s_resp = RES_DVA;
      else if (hit && k <= a) sw_if.s_resp = 2'($urandom_range(0, 3));
      else sw_if.s_resp = RES_NULL;

      e_act  = hit && (k == 0);
      e_done = hit && (k == end_k);
      e_acc  = hit ? (k == cmd_k) : (k == 0);
      e_cmd  = (hit && k <= cmd_k && !(cmd_to && k == T)) ? cmd : CMD_IDLE;
      e_resp = RES_NULL;
      e_data = 32'd0;
      if (!hit) begin
        if (rd && k == 1) e_resp = RES_ERR;
      end else if (rd && err && k == T) begin
        e_resp = RES_ERR;
      end else if (rd && !err && k == a + r) begin
        e_resp = RES_DVA;
        e_data = rdata;
      end else if (rd && k > a && k < end_k) begin
        e_data = rdata;
      end

      @(negedge clk);
      tg = $sformatf("t%0d k%0d", txn_id, k);
      check({tg, " act"}, 32'(act), 32'(e_act));
      check({tg, " done"}, 32'(done), 32'(e_done));
      check({tg, " acc"}, 32'(cpu_if.s_cmd_accept), 32'(e_acc));
      check({tg, " mcmd"}, 32'(sw_if.m_cmd), 32'(e_cmd));
      check({tg, " resp"}, 32'(cpu_if.s_resp), 32'(e_resp));
      check({tg, " sdata"}, cpu_if.s_data, e_data);
      check({tg, " maddr"}, sw_if.m_addr, addr);
      check({tg, " mdata"}, sw_if.m_data, wdata);
      if (hit) check({tg, " portno"}, 32'(portno), 32'(port));
      @(posedge clk);
    end
  endtask

  initial begin
    logic        rd;
    logic [31:0] addr;
    int          sel;
    int          a;
    int          r;

    n_checks = 0;
    n_errors = 0;
    txn_id   = 0;

    // Reset with a live-looking command on both sides: outputs must stay quiet.
    rst                 = 1'b1;
    cpu_if.m_addr       = 32'h2000_0000;
    cpu_if.m_cmd        = CMD_RD;
    cpu_if.m_data       = 32'd0;
    cpu_if.m_byte_en    = 4'hF;
    sw_if.s_cmd_accept  = 1'b1;
    sw_if.s_resp        = RES_DVA;
    sw_if.s_data        = 32'h1234_5678;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle($sformatf("reset%0d", i));
      @(posedge clk);
    end
    #1;
    rst                = 1'b0;
    cpu_if.m_cmd       = CMD_IDLE;
    cpu_if.m_addr      = 32'd0;
    sw_if.s_cmd_accept = 1'b0;
    sw_if.s_resp       = RES_NULL;
    @(negedge clk);
    check_idle("post_reset");
    @(posedge clk);

    run_txn(1'b1, 32'h2000_0010, 0, 3, 32'hDEAD_BEEF, 1);
    run_txn(1'b0, 32'h1000_0000, 2, 1, 32'h0, 1);
    run_txn(1'b0, 32'h4000_0004, 0, 1, 32'h0, 0);
    run_txn(1'b1, 32'h4000_0008, 0, 1, 32'hCAFE_0001, 1);
    run_txn(1'b1, 32'hF000_0000, 0, 1, 32'h5555_AAAA, 1);
    run_txn(1'b0, 32'h8000_0000, 0, 1, 32'h0, 1);
    run_txn(1'b1, 32'h0000_0000, 0, 10, 32'h7777_0000, 1);
    run_txn(1'b1, 32'h0000_0100, 8, 2, 32'h1, 1);
    run_txn(1'b0, 32'h3000_0000, 8, 1, 32'h0, 0);
    run_txn(1'b0, 32'h3000_0000, 9, 1, 32'h0, 1);
    run_txn(1'b1, 32'h1000_0020, 3, 5, 32'hABCD_0123, 0);

    // Reset while waiting for a read response: no done, idle outputs after.
    #1;
    cpu_if.m_addr      = 32'h3000_0000;
    cpu_if.m_cmd       = CMD_RD;
    sw_if.s_cmd_accept = 1'b1;
    sw_if.s_resp       = RES_NULL;
    @(negedge clk);
    check("rstmid k0 act", 32'(act), 32'd1);
    check("rstmid k0 portno", 32'(portno), 32'd3);
    @(posedge clk);
    #1;
    cpu_if.m_cmd       = CMD_IDLE;
    sw_if.s_cmd_accept = 1'b0;
    @(negedge clk);
    check("rstmid k1 done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    sw_if.s_resp = RES_DVA;
    @(negedge clk);
    check_idle("rstmid k2");
    @(posedge clk);
    #1;
    rst           = 1'b0;
    sw_if.s_resp  = RES_NULL;
    cpu_if.m_addr = 32'd0;
    @(negedge clk);
    check_idle("rstmid k3");
    @(posedge clk);
    run_txn(1'b1, 32'h3000_0040, 1, 2, 32'h0BAD_F00D, 1);

    for (int n = 0; n < 250; n++) begin
      rd  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 6);
      if (sel < 5) addr = (32'(sel) << 28) | ($urandom & 32'h0FFF_FFFF);
      else addr = (32'($urandom_range(5, 15)) << 28) | ($urandom & 32'h0FFF_FFFF);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 11) : $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(1, 3);
      run_txn(rd, addr, a, r, $urandom, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
